// File: rtl/jesd204_rx_pkg.sv
// rtl/jesd204_rx_pkg.sv - link geometry constants and FSM state encoding for the rx transport layer
package jesd204_rx_pkg;

    localparam int LANES            = 4;
    localparam int OCTETS_PER_LANE  = 4;
    localparam int CONVERTERS       = 2;
    localparam int SAMPLE_W         = 16;
    localparam int SAMPLES_PER_BEAT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } rx_state_t;

endpackage

// File: rtl/jesd204_rx_transport_if.sv
// rtl/jesd204_rx_transport_if.sv - lane input stream and sample output stream bundle
interface jesd204_rx_transport_if;
    import jesd204_rx_pkg::*;

    logic                                       rx_tvalid;
    logic [LANES-1:0][8*OCTETS_PER_LANE-1:0]    rx_tdata;
    logic                                       m_tvalid;
    logic                                       m_tready;
    logic [SAMPLES_PER_BEAT-1:0][SAMPLE_W-1:0]  m_tdata;

    // master: the transport block (consumes lanes, produces samples)
    modport master (
        input  rx_tvalid, rx_tdata, m_tready,
        output m_tvalid, m_tdata
    );

    modport slave (
        output rx_tvalid, rx_tdata, m_tready,
        input  m_tvalid, m_tdata
    );
endinterface

// File: rtl/jesd204_rx_fifo.sv
// rtl/jesd204_rx_fifo.sv - synchronous show-ahead FIFO with extended-pointer full/empty
module jesd204_rx_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_rd;
    logic             do_wr;

    assign do_rd = rd_en && !empty;
    // a full FIFO still accepts a write when the head leaves in the same cycle
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/jesd204_rx_transport.sv
// rtl/jesd204_rx_transport.sv - L4 M2 F1 S1 transport unpacker with capture FSM, FIFO and drop status
module jesd204_rx_transport
    import jesd204_rx_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int CTRL_BITS = 0
) (
    input  logic                    clk,
    input  logic                    aresetn,
    input  logic                    enable,
    input  logic                    clr_status,
    jesd204_rx_transport_if.master  bus,
    output logic                    overflow,
    output logic [15:0]             drop_cnt,
    output logic [1:0]              state
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [SAMPLE_W-1:0] SAMPLE_MASK = ~((16'd1 << CTRL_BITS) - 16'd1);

    rx_state_t                                  state_q;
    rx_state_t                                  state_d;
    logic [SAMPLES_PER_BEAT-1:0][SAMPLE_W-1:0]  unpacked;
    logic                                       fifo_full;
    logic                                       fifo_empty;
    logic [CNT_W-1:0]                           fifo_count;
    logic                                       pop;
    logic                                       can_write;
    logic                                       flush_done;
    logic                                       wr_en;
    logic                                       cnt_inc;
    logic                                       set_ovf;

    // sample(f,c) = {lane 2c octet f, lane 2c+1 octet f}, stored at index 2f+c
    always_comb begin
        unpacked = '0;
        for (int f = 0; f < OCTETS_PER_LANE; f++) begin
            for (int c = 0; c < CONVERTERS; c++) begin
                unpacked[2*f+c] = {bus.rx_tdata[2*c][8*f +: 8], bus.rx_tdata[2*c+1][8*f +: 8]}
                                  & SAMPLE_MASK;
            end
        end
    end

    jesd204_rx_fifo #(
        .WIDTH (SAMPLES_PER_BEAT*SAMPLE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (aresetn),
        .wr_en   (wr_en),
        .wr_data (unpacked),
        .rd_en   (bus.m_tready),
        .rd_data (bus.m_tdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign bus.m_tvalid = !fifo_empty;
    assign pop          = !fifo_empty && bus.m_tready;
    assign can_write    = !fifo_full || pop;
    assign flush_done   = fifo_empty || ((fifo_count == CNT_W'(1)) && pop);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        cnt_inc = 1'b0;
        set_ovf = 1'b0;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_SYNC;
                ST_SYNC, ST_RUN: begin
                    if (bus.rx_tvalid) begin
                        if (can_write) begin
                            wr_en   = 1'b1;
                            state_d = ST_RUN;
                        end else begin
                            cnt_inc = 1'b1;
                            set_ovf = 1'b1;
                            state_d = ST_FLUSH;
                        end
                    end else if (state_q == ST_RUN) begin
                        state_d = ST_SYNC;
                    end
                end
                ST_FLUSH: begin
                    cnt_inc = bus.rx_tvalid;
                    if (flush_done) state_d = ST_SYNC;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // a clear that coincides with a drop leaves that drop recorded
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            overflow <= 1'b0;
            drop_cnt <= 16'd0;
        end else if (clr_status) begin
            overflow <= set_ovf;
            drop_cnt <= {15'd0, cnt_inc};
        end else begin
            if (set_ovf) overflow <= 1'b1;
            if (cnt_inc && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_jesd204_rx_transport.sv
// tb/tb_jesd204_rx_transport.sv - scoreboard bench for jesd204_rx_transport
module tb_jesd204_rx_transport;
    import jesd204_rx_pkg::*;

    localparam int DEPTH = 16;

    typedef logic [3:0][31:0] lanes_t;
    typedef logic [7:0][15:0] beat_t;

    logic   clk = 1'b0;
    logic   aresetn = 1'b0;
    logic   enable = 1'b0;
    logic   clr_status = 1'b0;
    logic   rx_tvalid = 1'b0;
    logic   m_tready = 1'b0;
    lanes_t rx_tdata = '0;

    logic        overflow0, overflow1;
    logic [15:0] drop_cnt0, drop_cnt1;
    logic [1:0]  state0, state1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jesd204_rx_transport_if bus0();
    jesd204_rx_transport_if bus1();

    assign bus0.rx_tvalid = rx_tvalid;
    assign bus0.rx_tdata  = rx_tdata;
    assign bus0.m_tready  = m_tready;
    assign bus1.rx_tvalid = rx_tvalid;
    assign bus1.rx_tdata  = rx_tdata;
    assign bus1.m_tready  = m_tready;

    jesd204_rx_transport #(.DEPTH(DEPTH), .CTRL_BITS(0)) dut0 (
        .clk        (clk),
        .aresetn    (aresetn),
        .enable     (enable),
        .clr_status (clr_status),
        .bus        (bus0),
        .overflow   (overflow0),
        .drop_cnt   (drop_cnt0),
        .state      (state0)
    );

    jesd204_rx_transport #(.DEPTH(DEPTH), .CTRL_BITS(2)) dut1 (
        .clk        (clk),
        .aresetn    (aresetn),
        .enable     (enable),
        .clr_status (clr_status),
        .bus        (bus1),
        .overflow   (overflow1),
        .drop_cnt   (drop_cnt1),
        .state      (state1)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // sample for frame f, converter c: high octet from lane 2c, low octet from lane 2c+1
    function automatic beat_t ref_unpack(input lanes_t lanes, input int ctrl);
        beat_t b;
        for (int f = 0; f < 4; f++) begin
            for (int c = 0; c < 2; c++) begin
                int hi, lo, s;
                hi = int'((lanes[2*c]   >> (8*f)) & 32'hFF);
                lo = int'((lanes[2*c+1] >> (8*f)) & 32'hFF);
                s  = hi * 256 + lo;
                s  = (s >> ctrl) << ctrl;
                b[2*f+c] = 16'(s);
            end
        end
        return b;
    endfunction

    // reference model: occupancy, mode and status, updated at each clock edge
    lanes_t exp_q[$];
    int     m_state = 0;
    int     m_occ   = 0;
    int     m_ovf   = 0;
    int     m_drop  = 0;

    always @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            m_state = 0;
            m_occ   = 0;
            m_ovf   = 0;
            m_drop  = 0;
            exp_q.delete();
        end else begin
            int pop, wr, inc, ovf_set, nxt;
            pop = (m_occ > 0 && m_tready) ? 1 : 0;
            wr = 0; inc = 0; ovf_set = 0; nxt = m_state;
            if (!enable) nxt = 0;
            else if (m_state == 0) nxt = 1;
            else if (m_state == 1 || m_state == 2) begin
                if (rx_tvalid) begin
                    if (m_occ < DEPTH || pop == 1) begin wr = 1; nxt = 2; end
                    else begin inc = 1; ovf_set = 1; nxt = 3; end
                end else nxt = 1;
            end else begin
                if (rx_tvalid) inc = 1;
                if (m_occ - pop == 0) nxt = 1;
            end
            m_occ = m_occ - pop + wr;
            if (wr == 1) exp_q.push_back(rx_tdata);
            if (clr_status) begin
                m_ovf  = ovf_set;
                m_drop = inc;
            end else begin
                if (ovf_set == 1) m_ovf = 1;
                if (inc == 1 && m_drop < 65535) m_drop++;
            end
            m_state = nxt;
        end
    end

    // monitor: compares every presented beat and the status outputs against the model
    always @(negedge clk) begin
        if (aresetn) begin
            check("m_tvalid", bus0.m_tvalid, (m_occ > 0) ? 1 : 0);
            check("state", state0, m_state);
            check("overflow", overflow0, m_ovf);
            check("drop_cnt", drop_cnt0, m_drop);
            if (bus0.m_tvalid && exp_q.size() > 0) begin
                check("m_tdata", bus0.m_tdata, ref_unpack(exp_q[0], 0));
                check("m_tdata_ctrl2", bus1.m_tdata, ref_unpack(exp_q[0], 2));
                if (m_tready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic drive(input logic en, input logic v, input logic r, input logic c, input lanes_t d);
        enable = en; rx_tvalid = v; m_tready = r; clr_status = c; rx_tdata = d;
        @(posedge clk);
        #1;
    endtask

    function automatic lanes_t rnd_lanes();
        lanes_t l;
        for (int i = 0; i < 4; i++) l[i] = $urandom;
        return l;
    endfunction

    lanes_t map_lanes;

    initial begin
        map_lanes = {32'h00FFEEDD, 32'hCCBBAA99, 32'h88776655, 32'h44332211};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_state", state0, 0);
        check("rst_m_tvalid", bus0.m_tvalid, 0);
        check("rst_m_tdata", bus0.m_tdata, 0);
        check("rst_overflow", overflow0, 0);
        check("rst_drop_cnt", drop_cnt0, 0);
        @(posedge clk);
        #1 aresetn = 1'b1;

        // fixed mapping beat
        drive(1, 0, 1, 0, '0);
        drive(1, 1, 1, 0, map_lanes);
        @(negedge clk);
        check("map_s0", bus0.m_tdata[0], 16'h1155);
        check("map_s1", bus0.m_tdata[1], 16'h99DD);
        check("map_s6", bus0.m_tdata[6], 16'h4488);
        check("map_s7", bus0.m_tdata[7], 16'hCC00);
        check("map_ctrl2_s0", bus1.m_tdata[0], 16'h1154);
        check("map_state_run", state0, 2);
        drive(1, 0, 1, 0, '0);

        // link loss for one cycle
        drive(1, 1, 1, 0, rnd_lanes());
        drive(1, 0, 1, 0, '0);
        @(negedge clk);
        check("linkloss_sync", state0, 1);
        drive(1, 1, 1, 0, rnd_lanes());
        @(negedge clk);
        check("linkloss_run", state0, 2);
        check("linkloss_valid", bus0.m_tvalid, 1);
        drive(1, 0, 1, 0, '0);

        // overflow, flush drops, then drain in order
        for (int i = 0; i < 17; i++) drive(1, 1, 0, 0, rnd_lanes());
        @(negedge clk);
        check("ovf_flag", overflow0, 1);
        check("ovf_drop1", drop_cnt0, 1);
        check("ovf_flush", state0, 3);
        for (int i = 0; i < 3; i++) drive(1, 1, 0, 0, rnd_lanes());
        @(negedge clk);
        check("ovf_drop4", drop_cnt0, 4);
        for (int i = 0; i < 16; i++) drive(1, 0, 1, 0, '0);
        @(negedge clk);
        check("flush_to_sync", state0, 1);
        check("flush_empty", bus0.m_tvalid, 0);

        // clear coincident with a drop
        for (int i = 0; i < 16; i++) drive(1, 1, 0, 0, rnd_lanes());
        drive(1, 1, 0, 1, rnd_lanes());
        @(negedge clk);
        check("clr_drop_cnt", drop_cnt0, 1);
        check("clr_drop_ovf", overflow0, 1);
        for (int i = 0; i < 16; i++) drive(1, 0, 1, 0, '0);
        drive(1, 0, 0, 1, '0);
        @(negedge clk);
        check("clr_alone_cnt", drop_cnt0, 0);
        check("clr_alone_ovf", overflow0, 0);

        // full FIFO with a simultaneous pop and write
        for (int i = 0; i < 16; i++) drive(1, 1, 0, 0, rnd_lanes());
        drive(1, 1, 1, 0, rnd_lanes());
        @(negedge clk);
        check("fullpop_ovf", overflow0, 0);
        check("fullpop_drop", drop_cnt0, 0);
        check("fullpop_state", state0, 2);
        for (int i = 0; i < 16; i++) drive(1, 0, 1, 0, '0);

        // reset with buffered beats and nonzero status
        for (int i = 0; i < 17; i++) drive(1, 1, 0, 0, rnd_lanes());
        for (int i = 0; i < 5; i++) drive(1, 1, 0, 0, rnd_lanes());
        #2 aresetn = 1'b0;
        #1;
        check("rstmid_m_tvalid", bus0.m_tvalid, 0);
        check("rstmid_state", state0, 0);
        check("rstmid_overflow", overflow0, 0);
        check("rstmid_drop_cnt", drop_cnt0, 0);
        check("rstmid_m_tdata", bus0.m_tdata, 0);
        enable = 0; rx_tvalid = 0;
        @(posedge clk);
        #1 aresetn = 1'b1;
        drive(0, 0, 1, 0, '0);
        @(negedge clk);
        check("rstmid_no_beat", bus0.m_tvalid, 0);

        // randomized traffic against the model
        for (int ph = 0; ph < 12; ph++) begin
            int rdy_pct;
            rdy_pct = (ph % 3 == 0) ? 15 : ((ph % 3 == 1) ? 55 : 95);
            for (int i = 0; i < 200; i++) begin
                drive(($urandom_range(0, 39) != 0),
                      ($urandom_range(0, 3) != 0),
                      ($urandom_range(0, 99) < rdy_pct),
                      ($urandom_range(0, 63) == 0),
                      rnd_lanes());
            end
        end
        for (int i = 0; i < 24; i++) drive(1, 0, 1, 0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jesd204_rx_transport.md
JESD204_RX_TRANSPORT -- requirements
Module: jesd204_rx_transport

Interface
REQ-001 Parameter DEPTH, default 16, FIFO depth in beats; power of two, minimum 4.
REQ-002 Parameter CTRL_BITS, default 0, number of sample LSBs forced to zero (0..2).
REQ-003 CLK  in  1  single clock for all logic (rx core clock); all ports synchronous to it.
REQ-004 ARESETN  in  1  asynchronous active-low reset.
REQ-005 ENABLE  in  1  arms capture.
REQ-006 RX_TVALID  in  1  link user-data valid; there is no backpressure path.
REQ-007 RX_TDATA  in  [3:0][31:0]  lane data; the first octet in time is in bits [7:0].
REQ-008 M_TVALID  out  1  sample beat valid.
REQ-009 M_TREADY  in  1  downstream ready.
REQ-010 M_TDATA  out  [7:0][15:0]  samples; index = 2*frame + converter.
REQ-011 OVERFLOW  out  1  sticky overflow flag.
REQ-012 DROP_CNT  out  16  saturating count of dropped beats.
REQ-013 CLR_STATUS  in  1  single-cycle pulse that clears OVERFLOW and DROP_CNT.
REQ-014 STATE  out  2  current FSM state code.

Function
REQ-015 Link configuration: L=4, M=2, F=1, S=1, N'=16; each input beat carries 4 frames (f=0..3).
REQ-016 Frame f, converter c sample = {lane 2c octet f, lane 2c+1 octet f}, MSB octet first; low CTRL_BITS bits are zeroed.
REQ-017 Unpacking is combinational into the FIFO write port; the FIFO is registered, show-ahead.
REQ-018 A beat written in cycle t is visible on M_TDATA in cycle t+1 when the FIFO was empty.
REQ-019 M_TVALID = FIFO not empty; M_TDATA and M_TVALID stay stable while M_TVALID=1 and M_TREADY=0.
REQ-020 A beat pops on M_TVALID & M_TREADY.
REQ-021 FSM states: IDLE=0, SYNC=1, RUN=2, FLUSH=3.
REQ-022 IDLE: no writes; ENABLE=1 -> SYNC.
REQ-023 SYNC: RX_TVALID=1 -> write that beat, go to RUN.
REQ-024 RUN: each RX_TVALID=1 beat is written.
REQ-025 RUN: RX_TVALID=0 -> SYNC; FIFO contents are retained.
REQ-026 A write is accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-027 Otherwise the beat is dropped: OVERFLOW<=1, DROP_CNT increments, state -> FLUSH.
REQ-028 FLUSH: no writes; every RX_TVALID=1 beat increments DROP_CNT.
REQ-029 FLUSH: FIFO empty (after any pop that cycle) -> SYNC.
REQ-030 ENABLE=0 in any state -> IDLE next cycle; ENABLE has priority over all other transitions.
REQ-031 ENABLE=0 does not clear the FIFO; the FIFO keeps draining.
REQ-032 DROP_CNT saturates at 16'hFFFF.
REQ-033 CLR_STATUS coincident with a drop: result OVERFLOW=1, DROP_CNT=1.
REQ-034 The FIFO read pointer wraps modulo DEPTH; the write pointer wraps modulo DEPTH.
REQ-035 Full/empty are derived from pointers extended by one bit.

Reset
REQ-036 ARESETN=0 asynchronously forces STATE=IDLE, FIFO empty, M_TVALID=0, M_TDATA=0, OVERFLOW=0, DROP_CNT=0.
REQ-037 Reset asserted mid-transfer discards all buffered beats; no partial beat is emitted after reset release.
REQ-038 Reset deassertion is used as-is and is synchronised externally.

Structure
REQ-039 Package jesd204_rx_pkg holds: the state enum, and constants LANES=4, OCTETS_PER_LANE=4, CONVERTERS=2, SAMPLE_W=16, SAMPLES_PER_BEAT=8.
REQ-040 One sub-module, jesd204_rx_fifo: synchronous, show-ahead, parameterised by width and DEPTH, with full, empty and count outputs.
REQ-041 Unpacking, the FSM and the status counters live in the top module.

Verification
REQ-042 Mapping: ENABLE=1, one beat with lane0=32'h44332211, lane1=32'h88776655, lane2=32'hCCBBAA99, lane3=32'h00FFEEDD, M_TREADY=1 -> next cycle M_TDATA[0]=16'h1155, [1]=16'h99DD, [6]=16'h4488, [7]=16'hCC00.
REQ-043 CTRL_BITS=2, same stimulus -> M_TDATA[0]=16'h1154.
REQ-044 Overflow: DEPTH=16, M_TREADY=0, 17 valid beats -> 16 stored, OVERFLOW=1, DROP_CNT=1, STATE=FLUSH; 3 more beats -> DROP_CNT=4; M_TREADY=1 for 16 pops -> SYNC, the 16 beats arrive in order.
REQ-045 Full with a simultaneous pop: FIFO full, M_TREADY=1 and RX_TVALID=1 in the same cycle -> no drop, OVERFLOW stays 0.
REQ-046 Link loss: in RUN, RX_TVALID drops for 1 cycle -> STATE=SYNC; the next valid beat is written and STATE=RUN.
REQ-047 Reset/clear:
- ARESETN pulsed low with 5 beats buffered -> M_TVALID=0 and all status outputs zero.
- CLR_STATUS concurrent with a drop -> DROP_CNT=1.
